ita_hwpe_cfg_programmer: RTL and testbench
==========================================

Name: ita_hwpe_cfg_programmer

Overview:
- Configuration initiator on the ITA HWPE peripheral (config) port; the counterpart of the ITA register file.
- Accepts one packed job descriptor of ITA_IO_REGS 32-bit words and performs the full offload sequence: acquire, program all job registers, trigger, wait for the end-of-job event.
- Sits between a cluster-side job queue (or a test sequencer) and the ITA HWPE control slave, so ITA layers can be chained without core intervention.

Parameters:
- ITA_IO_REGS, 20, number of job registers written per job, in register-map order 0..ITA_IO_REGS-1.
- ID_WIDTH, 2, width of the peripheral transaction ID.
- BASE_ADDR, 32'h0000_0000, HWPE peripheral base address.
- REG_TRIGGER_OFS, 32'h00, offset of the TRIGGER register.
- REG_ACQUIRE_OFS, 32'h04, offset of the ACQUIRE register.
- REG_JOB_OFS, 32'h40, offset of job register 0; job register i is at REG_JOB_OFS+4*i.
- ACQ_RETRY_MAX, 16, maximum number of failed ACQUIRE reads before the job is aborted.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- job_valid_i  in  1  descriptor valid.
- job_ready_o  out  1  descriptor accepted; high only in IDLE.
- job_regs_i  in  32*ITA_IO_REGS  descriptor; word i is in bits [32*i+31:32*i].
- cfg_req_o  out  1  peripheral request.
- cfg_gnt_i  in  1  peripheral grant.
- cfg_add_o  out  32  byte address.
- cfg_wen_o  out  1  1 = read, 0 = write.
- cfg_be_o  out  4  byte enables; always 4'hF.
- cfg_data_o  out  32  write data.
- cfg_id_o  out  ID_WIDTH  transaction ID; always 0.
- cfg_r_data_i  in  32  read data.
- cfg_r_valid_i  in  1  read response valid.
- evt_i  in  1  HWPE end-of-job event (single-cycle pulse).
- busy_o  out  1  high while not IDLE.
- done_o  out  1  single-cycle pulse when a job finishes or aborts.
- err_o  out  1  valid with done_o; 1 = acquire retries exhausted.
- job_id_o  out  8  ACQUIRE return value [7:0]; valid with done_o.

Behaviour:
- Reset values: all outputs 0, except cfg_wen_o = 1 and cfg_be_o = 4'hF. State = IDLE; all counters and the descriptor register are cleared.
- Reset mid-operation: the FSM returns to IDLE on the next edge and cfg_req_o drops even if not yet granted. No done_o is produced.
- Request rule: once cfg_req_o rises, cfg_add_o, cfg_wen_o and cfg_data_o stay stable until the cycle in which cfg_gnt_i = 1.
  - A write completes on grant.
  - A read completes on the first cfg_r_valid_i after its grant.
  - Only one transaction is outstanding at a time.
- IDLE: job_ready_o = 1. When job_valid_i = 1, latch job_regs_i, clear the retry count, and go to ACQ_REQ.
- ACQ_REQ: issue a read to BASE_ADDR+REG_ACQUIRE_OFS. On grant, go to ACQ_RSP.
- ACQ_RSP: wait for cfg_r_valid_i.
  - If cfg_r_data_i[31] = 1 (engine locked), increment the retry count.
    - If the count reaches ACQ_RETRY_MAX, go to FINISH with err = 1.
    - Otherwise go to ACQ_WAIT.
  - Otherwise store job_id and go to WRITE with idx = 0.
- ACQ_WAIT: idle for 4 cycles, then go to ACQ_REQ.
- WRITE: issue a write of descriptor word idx to BASE_ADDR+REG_JOB_OFS+4*idx.
  - On grant with idx = ITA_IO_REGS-1, go to TRIG. Otherwise increment idx.
  - The next request may be issued in the cycle after the grant (back-to-back, 1 cycle/word with constant grant).
- TRIG: write 32'h0 to BASE_ADDR+REG_TRIGGER_OFS. On grant, go to WAIT_EVT.
- WAIT_EVT: on evt_i = 1, go to FINISH with err = 0. evt_i is ignored in every other state.
- FINISH: pulse done_o for 1 cycle with err_o and job_id_o valid, then go to IDLE. job_ready_o stays 0 during FINISH.
- cfg_r_valid_i outside ACQ_RSP is ignored.
- Latency with cfg_gnt_i tied high and 1-cycle read response, counted from job accept to trigger grant: ACQ_REQ 1 + ACQ_RSP 1 + WRITE ITA_IO_REGS + TRIG 1 = 23 cycles.
- idx counter width is $clog2(ITA_IO_REGS). Retry counter width is $clog2(ACQ_RETRY_MAX+1). Both saturate rather than wrap.

Test Plan:
- Basic job: descriptor word i = 32'hA000_0000+i, gnt tied 1, ACQUIRE returns 32'h0000_0003, evt pulsed 10 cycles after trigger.
  - 20 writes to 0x40..0x8C with matching data, then a write of 0 to 0x00.
  - done_o pulses with err_o = 0 and job_id_o = 3.
  - Trigger grant occurs 23 cycles after accept.
- Grant stalls: random cfg_gnt_i at 30% → address/data held stable while ungranted, no word skipped or duplicated, write order 0..19 preserved.
- Locked engine: ACQUIRE returns 32'hFFFF_FFFF twice, then 32'h1 → 3 ACQUIRE reads spaced by 4 idle cycles, then normal programming, job_id_o = 1.
- Retry exhaustion: ACQUIRE always returns 32'hFFFF_FFFF, ACQ_RETRY_MAX = 16 → exactly 16 reads, no writes, done_o with err_o = 1.
- Reset mid-WRITE: rst_i asserted at idx = 7 with req pending and ungranted → cfg_req_o = 0 the next cycle, busy_o = 0, no done_o. A new job then restarts from ACQUIRE.
- Spurious inputs: evt_i pulsed during WRITE and r_valid pulsed during WAIT_EVT → no state change. Only the later evt_i in WAIT_EVT completes the job.

Source files
------------

// File: rtl/ita_hwpe_cfg_programmer.sv
// Configuration initiator for the ITA HWPE peripheral port: acquires the engine,
// programs one job descriptor, triggers it and waits for the end-of-job event.
module ita_hwpe_cfg_programmer #(
  parameter int unsigned ITA_IO_REGS     = 20,
  parameter int unsigned ID_WIDTH        = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter logic [31:0] REG_TRIGGER_OFS = 32'h00,
  parameter logic [31:0] REG_ACQUIRE_OFS = 32'h04,
  parameter logic [31:0] REG_JOB_OFS     = 32'h40,
  parameter int unsigned ACQ_RETRY_MAX   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [32*ITA_IO_REGS-1:0] job_regs_i,
  output logic                      cfg_req_o,
  input  logic                      cfg_gnt_i,
  output logic [31:0]               cfg_add_o,
  output logic                      cfg_wen_o,
  output logic [3:0]                cfg_be_o,
  output logic [31:0]               cfg_data_o,
  output logic [ID_WIDTH-1:0]       cfg_id_o,
  input  logic [31:0]               cfg_r_data_i,
  input  logic                      cfg_r_valid_i,
  input  logic                      evt_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [7:0]                job_id_o
);

  localparam int unsigned IDX_W   = (ITA_IO_REGS > 1) ? $clog2(ITA_IO_REGS) : 1;
  localparam int unsigned RETRY_W = $clog2(ACQ_RETRY_MAX + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(ITA_IO_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_SAT  = RETRY_W'(ACQ_RETRY_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(ACQ_RETRY_MAX - 1);

  typedef enum logic [2:0] {
    IDLE, ACQ_REQ, ACQ_RSP, ACQ_WAIT, WRITE, TRIG, WAIT_EVT, FINISH
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic [1:0]                wait_q, wait_d;
  logic [32*ITA_IO_REGS-1:0] regs_q, regs_d;
  logic                      req_q, req_d;
  logic [31:0]               add_q, add_d;
  logic                      wen_q, wen_d;
  logic [31:0]               data_q, data_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [7:0]                job_id_q, job_id_d;

  // Only the lock flag and the job id of the ACQUIRE word carry meaning.
  logic unused_rdata;
  assign unused_rdata = ^cfg_r_data_i[30:8];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    wait_d   = wait_q;
    regs_d   = regs_q;
    req_d    = req_q;
    add_d    = add_q;
    wen_d    = wen_q;
    data_d   = data_q;
    err_d    = err_q;
    job_id_d = job_id_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready_q && job_valid_i) begin
          regs_d   = job_regs_i;
          retry_d  = '0;
          idx_d    = '0;
          job_id_d = '0;
          state_d  = ACQ_REQ;
          req_d    = 1'b1;
          add_d    = BASE_ADDR + REG_ACQUIRE_OFS;
          wen_d    = 1'b1;
          data_d   = '0;
        end
      end
      ACQ_REQ: begin
        if (cfg_gnt_i) begin
          req_d   = 1'b0;
          state_d = ACQ_RSP;
        end
      end
      ACQ_RSP: begin
        if (cfg_r_valid_i) begin
          if (cfg_r_data_i[31]) begin
            if (retry_q != RETRY_SAT) retry_d = retry_q + 1'b1;
            if (retry_q >= RETRY_LAST) begin
              state_d = FINISH;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = ACQ_WAIT;
              wait_d  = '0;
            end
          end else begin
            job_id_d = cfg_r_data_i[7:0];
            idx_d    = '0;
            state_d  = WRITE;
            req_d    = 1'b1;
            add_d    = BASE_ADDR + REG_JOB_OFS;
            wen_d    = 1'b0;
            data_d   = regs_q[31:0];
          end
        end
      end
      ACQ_WAIT: begin
        if (wait_q == 2'd3) begin
          state_d = ACQ_REQ;
          req_d   = 1'b1;
          add_d   = BASE_ADDR + REG_ACQUIRE_OFS;
          wen_d   = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WRITE: begin
        // Keep the request up across grants so words stream at one per cycle.
        if (cfg_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = TRIG;
            add_d   = BASE_ADDR + REG_TRIGGER_OFS;
            data_d  = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            add_d  = BASE_ADDR + REG_JOB_OFS + ((32'(idx_q) + 32'd1) << 2);
            data_d = regs_q[32*(int'(idx_q)+1) +: 32];
          end
        end
      end
      TRIG: begin
        if (cfg_gnt_i) begin
          req_d   = 1'b0;
          wen_d   = 1'b1;
          state_d = WAIT_EVT;
        end
      end
      WAIT_EVT: begin
        if (evt_i) begin
          state_d = FINISH;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      wait_q   <= '0;
      regs_q   <= '0;
      req_q    <= 1'b0;
      add_q    <= '0;
      wen_q    <= 1'b1;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      job_id_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      wait_q   <= wait_d;
      regs_q   <= regs_d;
      req_q    <= req_d;
      add_q    <= add_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      job_id_q <= job_id_d;
    end
  end

  assign job_ready_o = ready_q;
  assign cfg_req_o   = req_q;
  assign cfg_add_o   = add_q;
  assign cfg_wen_o   = wen_q;
  assign cfg_be_o    = 4'hF;
  assign cfg_data_o  = data_q;
  assign cfg_id_o    = '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign job_id_o    = job_id_q;

endmodule

// File: tb/tb_ita_hwpe_cfg_programmer.sv
// Bench for ita_hwpe_cfg_programmer: a bus responder plus a transaction-list
// reference model derived from the offload sequence.
module tb_ita_hwpe_cfg_programmer;

  localparam int REGS      = 20;
  localparam int RETRY_MAX = 16;
  localparam logic [31:0] ADDR_TRIG = 32'h00;
  localparam logic [31:0] ADDR_ACQ  = 32'h04;
  localparam logic [31:0] ADDR_JOB  = 32'h40;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   job_valid_i;
  logic                   job_ready_o;
  logic [32*REGS-1:0]     job_regs_i;
  logic                   cfg_req_o;
  logic                   cfg_gnt_i;
  logic [31:0]            cfg_add_o;
  logic                   cfg_wen_o;
  logic [3:0]             cfg_be_o;
  logic [31:0]            cfg_data_o;
  logic [1:0]             cfg_id_o;
  logic [31:0]            cfg_r_data_i;
  logic                   cfg_r_valid_i;
  logic                   evt_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;
  logic [7:0]             job_id_o;

  ita_hwpe_cfg_programmer #(
    .ITA_IO_REGS(REGS), .ID_WIDTH(2), .BASE_ADDR(32'h0),
    .REG_TRIGGER_OFS(ADDR_TRIG), .REG_ACQUIRE_OFS(ADDR_ACQ),
    .REG_JOB_OFS(ADDR_JOB), .ACQ_RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs_i),
    .cfg_req_o(cfg_req_o), .cfg_gnt_i(cfg_gnt_i), .cfg_add_o(cfg_add_o),
    .cfg_wen_o(cfg_wen_o), .cfg_be_o(cfg_be_o), .cfg_data_o(cfg_data_o),
    .cfg_id_o(cfg_id_o), .cfg_r_data_i(cfg_r_data_i), .cfg_r_valid_i(cfg_r_valid_i),
    .evt_i(evt_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .job_id_o(job_id_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  logic [31:0] desc [REGS];
  logic [31:0] acq_list [$];
  logic [31:0] acq_default;
  int          acq_ptr;
  int          gnt_prob;
  int          rsp_delay;
  int          rsp_cnt;
  bit          rsp_pending;
  bit          block_en;
  logic [31:0] block_addr;
  int          evt_delay;
  int          evt_at;
  bit          spur_evt, spur_evt_done, spur_rvalid;

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        log_wen  [$];
  int          log_cycle[$];
  int          wr_seen, done_cnt, done_cycle, trig_cycle, accept_cycle;
  logic        done_err;
  logic [7:0]  done_id;

  bit          prev_pending;
  logic [31:0] prev_add, prev_data;
  logic        prev_wen;

  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic        exp_wen  [$];
  logic        exp_err;
  logic [7:0]  exp_id;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
    end
  endtask

  // One clock of the bus responder; everything observed here is stable since the last posedge.
  task automatic stepCycle();
    @(negedge clk_i);
    cycle++;
    if (prev_pending && !rst_i) begin
      checkOutput("hold_req", 64'(cfg_req_o), 64'd1);
      checkOutput("hold_add", {31'd0, cfg_wen_o, cfg_add_o}, {31'd0, prev_wen, prev_add});
      checkOutput("hold_data", 64'(cfg_data_o), 64'(prev_data));
    end
    cfg_r_valid_i = 1'b0;
    cfg_r_data_i  = $urandom;
    if (rsp_pending) begin
      if (rsp_cnt <= 1) begin
        cfg_r_valid_i = 1'b1;
        cfg_r_data_i  = (acq_ptr < acq_list.size()) ? acq_list[acq_ptr] : acq_default;
        acq_ptr++;
        rsp_pending = 1'b0;
      end else begin
        rsp_cnt--;
      end
    end else if (spur_rvalid && trig_cycle >= 0 && cycle == trig_cycle + 3) begin
      cfg_r_valid_i = 1'b1;
      cfg_r_data_i  = 32'h0000_0042;
    end
    evt_i = (evt_at >= 0 && cycle == evt_at);
    if (spur_evt && !spur_evt_done && wr_seen == 5) begin
      evt_i = 1'b1;
      spur_evt_done = 1'b1;
    end
    cfg_gnt_i = ($urandom_range(99) < gnt_prob);
    if (block_en && cfg_req_o && cfg_add_o == block_addr) cfg_gnt_i = 1'b0;
    if (cfg_req_o && cfg_gnt_i) begin
      log_addr.push_back(cfg_add_o);
      log_data.push_back(cfg_data_o);
      log_wen.push_back(cfg_wen_o);
      log_cycle.push_back(cycle);
      if (cfg_wen_o) begin
        rsp_pending = 1'b1;
        rsp_cnt     = rsp_delay;
      end else begin
        wr_seen++;
        if (cfg_add_o == ADDR_TRIG) begin
          trig_cycle = cycle;
          evt_at     = cycle + evt_delay;
        end
      end
    end
    if (done_o) begin
      done_cnt++;
      done_cycle = cycle;
      done_err   = err_o;
      done_id    = job_id_o;
      checkOutput("ready_in_finish", 64'(job_ready_o), 64'd0);
    end
    prev_pending = cfg_req_o && !cfg_gnt_i;
    prev_add     = cfg_add_o;
    prev_data    = cfg_data_o;
    prev_wen     = cfg_wen_o;
  endtask

  // Reference: the ordered list of bus transactions one job must produce.
  task automatic buildExpected();
    int locks = 0;
    logic [31:0] rsp;
    exp_addr.delete(); exp_data.delete(); exp_wen.delete();
    exp_err = 1'b1;
    exp_id  = 8'h00;
    for (int n = 0; n < RETRY_MAX; n++) begin
      exp_addr.push_back(ADDR_ACQ); exp_data.push_back(32'h0); exp_wen.push_back(1'b1);
      rsp = (n < acq_list.size()) ? acq_list[n] : acq_default;
      if (rsp[31]) begin
        locks++;
      end else begin
        exp_err = 1'b0;
        exp_id  = rsp[7:0];
        for (int i = 0; i < REGS; i++) begin
          exp_addr.push_back(ADDR_JOB + 32'(4 * i)); exp_data.push_back(desc[i]); exp_wen.push_back(1'b0);
        end
        exp_addr.push_back(ADDR_TRIG); exp_data.push_back(32'h0); exp_wen.push_back(1'b0);
        break;
      end
    end
  endtask

  task automatic clearLogs();
    log_addr.delete(); log_data.delete(); log_wen.delete(); log_cycle.delete();
    acq_ptr = 0; rsp_pending = 1'b0; evt_at = -1; trig_cycle = -1;
    spur_evt_done = 1'b0; wr_seen = 0; done_cnt = 0; done_cycle = -1;
  endtask

  task automatic acceptJob(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < REGS; i++) job_regs_i[32*i +: 32] = desc[i];
    for (int n = 0; n < 50 && !ok; n++) begin
      stepCycle();
      if (job_ready_o) begin
        job_valid_i  = 1'b1;
        accept_cycle = cycle;
        ok = 1'b1;
      end
    end
    if (!ok) checkOutput({name, "_accept"}, 64'd0, 64'd1);
    else begin
      stepCycle();
      job_valid_i = 1'b0;
      for (int i = 0; i < REGS; i++) job_regs_i[32*i +: 32] = $urandom;
    end
  endtask

  task automatic applyStimulus(input string name);
    bit ok;
    int n;
    clearLogs();
    buildExpected();
    acceptJob(name, ok);
    if (!ok) return;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      stepCycle();
      n++;
    end
    checkOutput({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) stepCycle();
    checkOutput({name, "_done_once"}, 64'(done_cnt), 64'd1);
    checkOutput({name, "_err"}, 64'(done_err), 64'(exp_err));
    if (!exp_err) begin
      checkOutput({name, "_job_id"}, 64'(done_id), 64'(exp_id));
      checkOutput({name, "_done_after_evt"}, 64'(done_cycle), 64'(evt_at + 1));
    end
    checkOutput({name, "_txn_count"}, 64'(log_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      checkOutput($sformatf("%s_txn%0d_addr", name, i), {31'd0, log_wen[i], log_addr[i]},
                  {31'd0, exp_wen[i], exp_addr[i]});
      if (!exp_wen[i])
        checkOutput($sformatf("%s_txn%0d_data", name, i), 64'(log_data[i]), 64'(exp_data[i]));
    end
    checkOutput({name, "_idle_ready"}, {62'd0, job_ready_o, busy_o}, 64'b10);
  endtask

  initial begin
    bit ok;
    int reads, n, locks;
    rst_i = 1'b1; job_valid_i = 1'b0; job_regs_i = '0; cfg_gnt_i = 1'b0;
    cfg_r_data_i = '0; cfg_r_valid_i = 1'b0; evt_i = 1'b0;
    gnt_prob = 100; rsp_delay = 1; evt_delay = 10; block_en = 1'b0; block_addr = '0;
    spur_evt = 1'b0; spur_rvalid = 1'b0; acq_default = 32'hFFFF_FFFF; prev_pending = 1'b0;
    clearLogs();

    repeat (3) stepCycle();
    checkOutput("rst_req", 64'(cfg_req_o), 64'd0);
    checkOutput("rst_wen_be_id", {58'd0, cfg_wen_o, cfg_be_o, cfg_id_o}, {58'd0, 1'b1, 4'hF, 2'd0});
    checkOutput("rst_status", {60'd0, job_ready_o, busy_o, done_o, err_o}, 64'd0);
    checkOutput("rst_job_id", 64'(job_id_o), 64'd0);
    rst_i = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("idle_ready", {62'd0, job_ready_o, busy_o}, 64'b10);

    // Basic job with the fixed descriptor pattern and a known trigger latency.
    for (int i = 0; i < REGS; i++) desc[i] = 32'hA000_0000 + 32'(i);
    acq_list = '{32'h0000_0003};
    applyStimulus("basic");
    checkOutput("basic_latency", 64'(trig_cycle - accept_cycle), 64'd23);

    // Grant stalls.
    for (int i = 0; i < REGS; i++) desc[i] = $urandom;
    acq_list = '{32'h0000_0005};
    gnt_prob = 30;
    applyStimulus("stall");
    gnt_prob = 100;

    // Locked engine twice, then acquired: reads spaced by response + 4 idle + request.
    for (int i = 0; i < REGS; i++) desc[i] = $urandom;
    acq_list = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    applyStimulus("locked");
    reads = 0;
    for (int i = 1; i < log_wen.size(); i++)
      if (log_wen[i] && log_wen[i-1])
        checkOutput($sformatf("locked_gap%0d", i), 64'(log_cycle[i] - log_cycle[i-1]), 64'd6);
    for (int i = 0; i < log_wen.size(); i++) if (log_wen[i]) reads++;
    checkOutput("locked_reads", 64'(reads), 64'd3);

    // Retry exhaustion.
    acq_list.delete();
    applyStimulus("exhaust");
    reads = 0;
    for (int i = 0; i < log_wen.size(); i++) if (log_wen[i]) reads++;
    checkOutput("exhaust_reads", 64'(reads), 64'(RETRY_MAX));
    checkOutput("exhaust_writes", 64'(wr_seen), 64'd0);

    // Reset while word 7 is requested but not granted.
    for (int i = 0; i < REGS; i++) desc[i] = $urandom;
    acq_list = '{32'h0000_0009};
    clearLogs();
    block_en = 1'b1; block_addr = ADDR_JOB + 32'd28;
    acceptJob("rstmid", ok);
    n = 0;
    while (!(prev_pending && cfg_add_o == block_addr) && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("rstmid_reached", 64'(prev_pending && cfg_add_o == block_addr), 64'd1);
    stepCycle();
    rst_i = 1'b1;
    stepCycle();
    checkOutput("rstmid_req", 64'(cfg_req_o), 64'd0);
    checkOutput("rstmid_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0; block_en = 1'b0;
    repeat (10) stepCycle();
    checkOutput("rstmid_no_done", 64'(done_cnt), 64'd0);
    acq_list = '{32'h0000_0011};
    applyStimulus("after_rst");

    // Spurious evt during WRITE and r_valid during WAIT_EVT.
    for (int i = 0; i < REGS; i++) desc[i] = $urandom;
    acq_list = '{32'h0000_0022};
    spur_evt = 1'b1; spur_rvalid = 1'b1; evt_delay = 12;
    applyStimulus("spurious");
    spur_evt = 1'b0; spur_rvalid = 1'b0;

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < REGS; i++) desc[i] = $urandom;
      acq_list.delete();
      locks = $urandom_range(0, 3);
      for (int k = 0; k < locks; k++) acq_list.push_back($urandom | 32'h8000_0000);
      acq_list.push_back($urandom & 32'h7FFF_FFFF);
      gnt_prob  = $urandom_range(30, 100);
      rsp_delay = $urandom_range(1, 3);
      evt_delay = $urandom_range(1, 20);
      applyStimulus($sformatf("rand%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
